// File: rtl/shift_add_pkg.sv
// Shared widths, FSM encoding and coefficient helper
// for the sequential shift-add fractional scaler.
package shift_add_pkg;

   localparam int DATA_W = 16;
   localparam int COEF_W = 8;
   localparam int IDX_W  = $clog2(COEF_W);
   localparam int AMT_W  = IDX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // True while a set bit remains below the one weighted by idx.
   function automatic logic last_set_remaining(
      input logic [COEF_W-1:0] c,
      input logic [IDX_W-1:0]  idx
   );
      logic r;
      r = 1'b0;
      for (int b = 0; b < COEF_W - 1; b++) begin
         if ((b < COEF_W - 1 - int'(idx)) && c[b]) r = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_add_scaler_shift_term.sv
// Gated right-shift term: data >> amt, or zero when disabled.
// The shift floors each partial product on its own.
module shift_term #(
   parameter int W = 16,
   parameter int A = 4
) (
   input  logic [W-1:0] data_i,
   input  logic [A-1:0] amt_i,
   input  logic         en_i,
   output logic [W-1:0] term_o
);

   assign term_o = en_i ? (data_i >> amt_i) : '0;

endmodule

// File: rtl/shift_add_scaler.sv
// Sequential Q0.8 scaler: one coefficient bit per cycle,
// stopping after the last set bit.
module shift_add_scaler
   import shift_add_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [COEF_W-1:0] coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [COEF_W-1:0] coef_q, coef_d;
   logic [DATA_W-1:0] acc_q, acc_d;

   logic [IDX_W-1:0]  bit_pos;
   logic [AMT_W-1:0]  amt;
   logic              term_en;
   logic [DATA_W-1:0] term;

   // idx 0 weighs the coef MSB by 1/2.
   assign bit_pos = IDX_W'(COEF_W - 1) - idx_q;
   assign amt     = AMT_W'(idx_q) + AMT_W'(1);
   assign term_en = (state_q == S_RUN) && coef_q[bit_pos];

   shift_term #(
      .W (DATA_W),
      .A (AMT_W)
   ) u_term (
      .data_i (data_q),
      .amt_i  (amt),
      .en_i   (term_en),
      .term_o (term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         coef_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         coef_q  <= coef_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      coef_d  = coef_q;
      acc_d   = acc_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = data_in;
               coef_d  = coef;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_q + term;
            idx_d = idx_q + IDX_W'(1);
            if (!last_set_remaining(coef_q, idx_q) ||
                (idx_q == IDX_W'(COEF_W - 1))) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = acc_q;

endmodule

// File: tb/tb_shift_add_scaler.sv
// Randomised and directed checks of shift_add_scaler
// against a per-term floor-sum reference model.
module tb_shift_add_scaler;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data_in;
   logic [7:0]  coef;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;

   int total;
   int bad;

   shift_add_scaler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .coef      (coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int ref_scale(input int d, input int c);
      int s;
      s = 0;
      for (int i = 0; i < 8; i++) begin
         if (((c >> (7 - i)) & 1) == 1) s += d / (2 ** (i + 1));
      end
      return s;
   endfunction

   function automatic int ref_lat(input int c);
      int low;
      if (c == 0) return 1;
      low = 0;
      while (((c >> low) & 1) == 0) low++;
      return 8 - low;
   endfunction

   task automatic run_op(input int d, input int c, input int bp, input bit poke);
      int exp_r;
      int exp_n;
      int n;
      bit low_rdy;
      exp_r = ref_scale(d, c);
      exp_n = ref_lat(c);
      in_valid = 1'b1;
      data_in  = 16'(d);
      coef     = 8'(c);
      chk("in_ready_idle", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = 16'($urandom);
      coef     = 8'($urandom);
      n = 0;
      low_rdy = 1'b1;
      while (!out_valid && n < 20) begin
         if (in_ready) low_rdy = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_run", int'(low_rdy), 1);
      chk("latency", n, exp_n);
      chk("result", int'(result), exp_r);
      out_ready = 1'b0;
      in_valid  = poke;
      data_in   = 16'($urandom);
      coef      = 8'($urandom);
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_result", int'(result), exp_r);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hs_valid_drop", int'(out_valid), 0);
      chk("hs_idle_ready", int'(in_ready), 1);
      in_valid = 1'b0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      coef      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      data_in  = 16'd5;
      coef     = 8'h80;
      @(posedge clk); #1;
      chk("rst_ignore_hs", int'(in_ready), 1);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(128, 8'h40, 0, 1'b0);
      run_op(9, 8'hA0, 0, 1'b0);
      run_op(16'hFFFF, 8'hFF, 0, 1'b0);
      run_op(1234, 8'h00, 0, 1'b0);
      run_op(1234, 8'h80, 0, 1'b0);
      run_op(777, 8'h01, 0, 1'b0);
      run_op(40000, 8'h35, 5, 1'b1);

      in_valid = 1'b1;
      data_in  = 16'hFFFF;
      coef     = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_acc", int'(result), 32767);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(100, 8'h80, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         run_op(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
